// File: rtl/music_pkg.sv
// music_pkg: tune select codes and arbiter state enum shared by the arbiter and musicplayer
//   SEL_* : 3-bit music_sel codes (off, song1, song2, success, fail)
//   arb_state_t : arbiter FSM states
package music_pkg;
   localparam logic [2:0] SEL_OFF     = 3'd0;
   localparam logic [2:0] SEL_SONG1   = 3'd1;
   localparam logic [2:0] SEL_SONG2   = 3'd2;
   localparam logic [2:0] SEL_SUCCESS = 3'd3;
   localparam logic [2:0] SEL_FAIL    = 3'd4;
   typedef enum logic [1:0] {ST_IDLE, ST_MUTE, ST_BGM, ST_JINGLE} arb_state_t;
   function automatic logic is_jingle(input logic [2:0] sel);
      return sel == SEL_SUCCESS || sel == SEL_FAIL;
   endfunction
endpackage

// File: rtl/tune_timer.sv
// tune_timer: loadable down-counter that stops at zero, used for mute gaps and jingle lengths
//   clk, rst      : clock, synchronous active-high reset (value -> 0)
//   load/load_val : load value on the next edge (load wins over counting)
//   value, zero   : current count and value == 0
module tune_timer #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   output logic [W-1:0] value,
   output logic         zero
);
   assign zero = value == '0;
   always_ff @(posedge clk) begin
      if (rst) value <= '0;
      else if (load) value <= load_val;
      else if (!zero) value <= value - 1'b1;
   end
endmodule

// File: rtl/music_request_arbiter.sv
// music_request_arbiter: shares the buzzer player between background music and payment jingles
//   clk, rst              : clock, synchronous active-high reset
//   bgm_en, bgm_song      : background music request level and song (1/2 valid)
//   pay_ok, pay_fail      : 1-cycle jingle requests (fail wins when simultaneous)
//   music_sel, music_en   : registered tune select and enable to the player
//   jingle_busy           : jingle muting or playing
//   jingle_done           : pulse in the cycle after a jingle's last playing cycle
module music_request_arbiter
   import music_pkg::*;
#(
   parameter int BEAT_CYCLES   = 25_000_000,
   parameter int SUCCESS_BEATS = 3,
   parameter int FAIL_BEATS    = 2,
   parameter int MUTE_CYCLES   = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       bgm_en,
   input  logic [1:0] bgm_song,
   input  logic       pay_ok,
   input  logic       pay_fail,
   output logic [2:0] music_sel,
   output logic       music_en,
   output logic       jingle_busy,
   output logic       jingle_done
);
   localparam int MAX_BEATS = SUCCESS_BEATS > FAIL_BEATS ? SUCCESS_BEATS : FAIL_BEATS;
   localparam int MAX_CNT = MUTE_CYCLES > MAX_BEATS * BEAT_CYCLES ? MUTE_CYCLES : MAX_BEATS * BEAT_CYCLES;
   localparam int CW = $clog2(MAX_CNT + 1);
   // Terminal count is reached at zero, so each load is one less than the duration
   localparam logic [CW-1:0] MUTE_LD = CW'(MUTE_CYCLES - 1);
   localparam logic [CW-1:0] SUCC_LD = CW'(SUCCESS_BEATS * BEAT_CYCLES - 1);
   localparam logic [CW-1:0] FAIL_LD = CW'(FAIL_BEATS * BEAT_CYCLES - 1);
   arb_state_t state, state_n;
   logic [2:0] target, target_n, pend, pend_n, pend_m, req, song, sel_n;
   logic bgm_ok, load, zero, en_n, busy_n, done_n;
   logic [CW-1:0] load_val, count;
   assign bgm_ok = bgm_en && (bgm_song == 2'd1 || bgm_song == 2'd2);
   tune_timer #(.W(CW)) u_timer (
      .clk(clk), .rst(rst), .load(load), .load_val(load_val), .value(count), .zero(zero)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         target      <= SEL_OFF;
         pend        <= SEL_OFF;
         music_sel   <= SEL_OFF;
         music_en    <= 1'b0;
         jingle_busy <= 1'b0;
         jingle_done <= 1'b0;
      end else begin
         state       <= state_n;
         target      <= target_n;
         pend        <= pend_n;
         music_sel   <= sel_n;
         music_en    <= en_n;
         jingle_busy <= busy_n;
         jingle_done <= done_n;
      end
   end
   always_comb begin
      req = pay_fail ? SEL_FAIL : (pay_ok ? SEL_SUCCESS : SEL_OFF);
      // Pending slot merge: fail overwrites ok, ok only fills an empty slot
      pend_m = (req == SEL_FAIL || (req == SEL_SUCCESS && pend == SEL_OFF)) ? req : pend;
      song = {1'b0, bgm_song};
      state_n = state;
      target_n = target;
      pend_n = pend;
      load = 1'b0;
      load_val = MUTE_LD;
      case (state)
         ST_IDLE: begin
            if (req != SEL_OFF || bgm_ok) begin
               state_n = ST_MUTE;
               target_n = req != SEL_OFF ? req : song;
               load = 1'b1;
            end
         end
         ST_BGM: begin
            if (req != SEL_OFF || (bgm_ok && song != target)) begin
               state_n = ST_MUTE;
               target_n = req != SEL_OFF ? req : song;
               load = 1'b1;
            end else if (!bgm_ok) state_n = ST_IDLE;
         end
         ST_MUTE: begin
            if (is_jingle(target)) begin
               pend_n = pend_m;
               if (zero) begin
                  state_n = ST_JINGLE;
                  load = 1'b1;
                  load_val = target == SEL_SUCCESS ? SUCC_LD : FAIL_LD;
               end
            end else if (req != SEL_OFF || (bgm_ok && song != target)) begin
               // Retarget the mute in progress and restart its gap
               target_n = req != SEL_OFF ? req : song;
               load = 1'b1;
            end else if (!bgm_ok) state_n = ST_IDLE;
            else if (zero) state_n = ST_BGM;
         end
         ST_JINGLE: begin
            pend_n = pend_m;
            if (zero) begin
               pend_n = SEL_OFF;
               state_n = (pend_m != SEL_OFF || bgm_ok) ? ST_MUTE : ST_IDLE;
               target_n = pend_m != SEL_OFF ? pend_m : song;
               load = pend_m != SEL_OFF || bgm_ok;
            end
         end
      endcase
   end
   always_comb begin
      sel_n = state_n == ST_IDLE ? SEL_OFF : target_n;
      en_n = state_n == ST_BGM || state_n == ST_JINGLE;
      busy_n = state_n == ST_JINGLE || (state_n == ST_MUTE && is_jingle(target_n));
      done_n = state == ST_JINGLE && zero;
   end
endmodule

// File: tb/tb_music_request_arbiter.sv
// tb_music_request_arbiter: directed scoreboard bench for music_request_arbiter
module tb_music_request_arbiter;
   logic clk = 1'b0;
   logic rst, bgm_en, pay_ok, pay_fail;
   logic [1:0] bgm_song;
   logic [2:0] music_sel;
   logic music_en, jingle_busy, jingle_done;
   int cyc = 0;
   int checks = 0;
   int errors = 0;
   int t;
   typedef struct {
      int c;
      logic [5:0] v;
   } exp_t;
   exp_t exp_q[$];
   logic [5:0] last = 6'h3f;
   music_request_arbiter #(
      .BEAT_CYCLES(4), .SUCCESS_BEATS(3), .FAIL_BEATS(2), .MUTE_CYCLES(2)
   ) dut (
      .clk(clk), .rst(rst), .bgm_en(bgm_en), .bgm_song(bgm_song), .pay_ok(pay_ok),
      .pay_fail(pay_fail), .music_sel(music_sel), .music_en(music_en),
      .jingle_busy(jingle_busy), .jingle_done(jingle_done)
   );
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      logic [5:0] cur;
      exp_t e;
      cur = {music_sel, music_en, jingle_busy, jingle_done};
      if (cur !== last) begin
         last = cur;
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_change cycle %0d got sel/en/busy/done %b", cyc, cur);
         end else begin
            e = exp_q.pop_front();
            if (e.v !== cur || e.c != cyc) begin
               errors++;
               $display("FAIL output_change got %b at cycle %0d, want %b at cycle %0d", cur, cyc, e.v, e.c);
            end
         end
      end
   end
   task automatic ex(input int c, input logic [2:0] s, input logic en, input logic b, input logic d);
      exp_t e;
      e.c = c;
      e.v = {s, en, b, d};
      exp_q.push_back(e);
   endtask
   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask
   initial begin
      rst = 1'b1; bgm_en = 1'b1; bgm_song = 2'd1; pay_ok = 1'b0; pay_fail = 1'b0;
      ex(1, 3'd0, 0, 0, 0);
      step(3);
      rst = 1'b0; t = cyc;
      ex(t + 1, 3'd1, 0, 0, 0); ex(t + 3, 3'd1, 1, 0, 0);
      step(6);
      t = cyc; pay_ok = 1'b1;
      ex(t + 1, 3'd3, 0, 1, 0); ex(t + 3, 3'd3, 1, 1, 0); ex(t + 15, 3'd1, 0, 0, 1);
      ex(t + 16, 3'd1, 0, 0, 0); ex(t + 17, 3'd1, 1, 0, 0);
      step(1); pay_ok = 1'b0; step(20);
      bgm_en = 1'b0; t = cyc;
      ex(t + 1, 3'd0, 0, 0, 0);
      step(3);
      t = cyc; pay_ok = 1'b1; pay_fail = 1'b1;
      ex(t + 1, 3'd4, 0, 1, 0); ex(t + 3, 3'd4, 1, 1, 0); ex(t + 11, 3'd0, 0, 0, 1);
      ex(t + 12, 3'd0, 0, 0, 0);
      step(1); pay_ok = 1'b0; pay_fail = 1'b0; step(15);
      t = cyc; pay_fail = 1'b1;
      ex(t + 1, 3'd4, 0, 1, 0); ex(t + 3, 3'd4, 1, 1, 0); ex(t + 11, 3'd4, 0, 1, 1);
      ex(t + 12, 3'd4, 0, 1, 0); ex(t + 13, 3'd4, 1, 1, 0); ex(t + 21, 3'd0, 0, 0, 1);
      ex(t + 22, 3'd0, 0, 0, 0);
      step(1); pay_fail = 1'b0; step(4);
      pay_fail = 1'b1; step(1);
      pay_fail = 1'b0; pay_ok = 1'b1; step(1);
      pay_ok = 1'b0; step(25);
      t = cyc; bgm_en = 1'b1; bgm_song = 2'd1;
      ex(t + 1, 3'd1, 0, 0, 0); ex(t + 3, 3'd1, 1, 0, 0);
      step(5);
      t = cyc; bgm_song = 2'd2;
      ex(t + 1, 3'd2, 0, 0, 0); ex(t + 3, 3'd2, 1, 0, 0);
      step(6);
      t = cyc; bgm_en = 1'b0;
      ex(t + 1, 3'd0, 0, 0, 0);
      step(4);
      t = cyc; bgm_en = 1'b1; bgm_song = 2'd1;
      ex(t + 1, 3'd1, 0, 0, 0); ex(t + 3, 3'd1, 1, 0, 0);
      step(5);
      t = cyc; pay_ok = 1'b1;
      ex(t + 1, 3'd3, 0, 1, 0); ex(t + 3, 3'd3, 1, 1, 0);
      step(1); pay_ok = 1'b0; step(5);
      rst = 1'b1;
      ex(t + 7, 3'd0, 0, 0, 0);
      step(2); rst = 1'b0;
      ex(t + 9, 3'd1, 0, 0, 0); ex(t + 11, 3'd1, 1, 0, 0);
      step(25);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL missing_changes %0d outstanding, want 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
